ad_scan_scheduler: RTL and testbench

- Sequencer that drives the AD7266 dual-channel read path.
- Issues one conversion start per programmable sample period and steps the 3-bit channel select through an enabled-channel mask.
- Waits for read-done with a timeout, then packs {channel, A result, B result} into a small FIFO.
- The FIFO drains through a valid/ready stream toward downstream processing in the AD top level.

---
 rtl/ad_scan_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_ad_scan_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_scan_scheduler.sv
// AD7266 scan sequencer: paced conversion starts over an enabled-channel mask,
// read-done wait with timeout, and a small result FIFO on a valid/ready stream.
module ad_scan_scheduler #(
    parameter int DIV_W      = 16,
    parameter int TIMEOUT    = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_PERIOD = 64
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] period,
    input  logic [5:0]       ch_mask,
    input  logic             clr_err,
    output logic             conv_start,
    output logic [2:0]       ch_sel,
    input  logic             rd_done,
    input  logic [11:0]      res_a,
    input  logic [11:0]      res_b,
    output logic [26:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             timeout_err,
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, WAIT_DONE, STORE} state_t;

    state_t           state;
    logic [DIV_W-1:0] per_cnt;
    logic [DIV_W-1:0] eff_period;
    logic [DIV_W-1:0] eff_next;
    logic             tick;
    logic             tick_pend;
    logic [TW-1:0]    to_cnt;
    logic [26:0]      cap;

    logic [26:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;

    function automatic logic [2:0] lowest_ch(input logic [5:0] m);
        lowest_ch = 3'd0;
        for (int i = 5; i >= 0; i--)
            if (m[i]) lowest_ch = 3'(i);
    endfunction

    // Nearest set bit above cur, wrapping; searched farthest-first so the nearest wins.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [5:0] m);
        logic [3:0] c;
        next_ch = cur;
        for (int i = 5; i >= 1; i--) begin
            c = {1'b0, cur} + 4'(i);
            if (c >= 4'd6) c = c - 4'd6;
            if (m[c[2:0]]) next_ch = c[2:0];
        end
    endfunction

    assign eff_next = (period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : period;
    assign tick     = (state != IDLE) && (per_cnt == eff_period - DIV_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt    <= '0;
            eff_period <= DIV_W'(MIN_PERIOD);
        end else if (state == IDLE || tick) begin
            per_cnt    <= '0;
            eff_period <= eff_next;
        end else begin
            per_cnt <= per_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch_sel      <= '0;
            conv_start  <= 1'b0;
            busy        <= 1'b0;
            tick_pend   <= 1'b0;
            to_cnt      <= '0;
            cap         <= '0;
            timeout_err <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            if (clr_err) timeout_err <= 1'b0;
            if (tick)    tick_pend   <= 1'b1;
            case (state)
                IDLE: begin
                    if (enable && ch_mask != '0) begin
                        state     <= WAIT_TICK;
                        ch_sel    <= lowest_ch(ch_mask);
                        tick_pend <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (!enable || ch_mask == '0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        tick_pend <= 1'b0;
                    end else if (tick_pend) begin
                        state      <= START;
                        conv_start <= 1'b1;
                        to_cnt     <= '0;
                    end
                end
                START: begin
                    if (!tick) tick_pend <= 1'b0;
                    to_cnt <= to_cnt + TW'(1);
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (rd_done) begin
                        cap   <= {ch_sel, res_a, res_b};
                        state <= STORE;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        ch_sel      <= next_ch(ch_sel, ch_mask);
                        state       <= WAIT_TICK;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                STORE: begin
                    ch_sel <= next_ch(ch_sel, ch_mask);
                    state  <= WAIT_TICK;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign push    = (state == STORE);
    assign pop     = m_valid && m_ready;
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign push_ok = push && (!full || pop);

    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (push_ok && !pop) count_next = count + (AW+1)'(1);
        if (!push_ok && pop) count_next = count - (AW+1)'(1);
    end

    // NOTE: the storage array is deliberately not reset; m_valid gates m_data instead.
    always_ff @(posedge sys_clk) begin
        if (push_ok) mem[wr_ptr] <= cap;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            m_valid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (clr_err)                overflow <= 1'b0;
            if (push && full && !pop)   overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            m_valid <= (count_next != '0);
        end
    end

    assign m_data = m_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ad_scan_scheduler.sv
// Bench for ad_scan_scheduler: a reader model answers conversions with random
// results, a scoreboard queue holds expected FIFO words, a monitor pops and compares.
module tb_ad_scan_scheduler;
    localparam int DIV_W      = 16;
    localparam int TIMEOUT    = 256;
    localparam int FIFO_DEPTH = 4;
    localparam int MIN_PERIOD = 64;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [DIV_W-1:0] period;
    logic [5:0]       ch_mask;
    logic             clr_err;
    logic             conv_start;
    logic [2:0]       ch_sel;
    logic             rd_done;
    logic [11:0]      res_a;
    logic [11:0]      res_b;
    logic [26:0]      m_data;
    logic             m_valid;
    logic             m_ready;
    logic             busy;
    logic             timeout_err;
    logic             overflow;

    ad_scan_scheduler #(
        .DIV_W(DIV_W), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH), .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .period(period),
        .ch_mask(ch_mask), .clr_err(clr_err), .conv_start(conv_start), .ch_sel(ch_sel),
        .rd_done(rd_done), .res_a(res_a), .res_b(res_b), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .timeout_err(timeout_err), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [26:0] exp_q[$];
    int  exp_ch;
    int  last_start = -1;
    int  rsp_delay  = 20;   // -1: never answer, 0: random 1..40, >0: fixed
    int  ready_mode = 1;    // 0: hold low, 1: always high, 2: random
    int  n_starts = 0;
    int  n_resp   = 0;
    int  n_pops   = 0;
    bit  exp_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_ch(input logic [5:0] m);
        for (int c = 0; c < 6; c++) if (m[c]) return c;
        return 0;
    endfunction

    function automatic int following_ch(input int cur, input logic [5:0] m);
        for (int c = cur + 1; c < 6; c++) if (m[c]) return c;
        return first_ch(m);
    endfunction

    // Reader model: answers conv_start, tracks expected channel order and spacing.
    initial begin
        int pend;
        int to_left;
        int cyc;
        int spacing;
        logic [11:0] a;
        logic [11:0] b;
        pend = -1; to_left = -1; cyc = 0;
        rd_done = 1'b0; res_a = '0; res_b = '0; m_ready = 1'b0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            rd_done = 1'b0;
            m_ready = (ready_mode == 1) ? 1'b1 :
                      (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!rst_n) begin
                pend = -1;
                to_left = -1;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        a = 12'($urandom_range(0, 4095));
                        b = 12'($urandom_range(0, 4095));
                        res_a = a; res_b = b; rd_done = 1'b1;
                        if (ready_mode == 0 && exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
                        else exp_q.push_back({3'(exp_ch), a, b});
                        n_resp++;
                        exp_ch = following_ch(exp_ch, ch_mask);
                        pend = -1;
                    end
                end
                if (to_left > 0) begin
                    to_left--;
                    if (to_left == 1) check("timeout_early", 32'(timeout_err), 0);
                    if (to_left == 0) begin
                        check("timeout_set", 32'(timeout_err), 1);
                        exp_ch = following_ch(exp_ch, ch_mask);
                        to_left = -1;
                    end
                end
                if (conv_start) begin
                    n_starts++;
                    check("ch_sel", 32'(ch_sel), 32'(exp_ch));
                    spacing = (int'(period) < MIN_PERIOD) ? MIN_PERIOD : int'(period);
                    if (last_start >= 0) check("start_spacing", 32'(cyc - last_start), 32'(spacing));
                    last_start = cyc;
                    if (rsp_delay < 0)       to_left = TIMEOUT;
                    else if (rsp_delay == 0) pend = $urandom_range(1, 40);
                    else                     pend = rsp_delay;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over a word.
    initial begin
        logic        held;
        logic [26:0] held_data;
        held = 1'b0; held_data = '0;
        forever begin
            @(negedge sys_clk);
            #1;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held && m_valid) check("m_data_stable", 32'(m_data), 32'(held_data));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) check("unexpected_pop", 32'(m_data), 0);
                    else begin
                        check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                        n_pops++;
                    end
                end
                held = m_valid && !m_ready;
                held_data = m_data;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
        #2;
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int k = 0;
        while (n_starts < target && k < budget) begin @(negedge sys_clk); k++; end
        #2;
        if (n_starts < target) check(name, 32'(n_starts), 32'(target));
    endtask

    task automatic wait_resp(input int target, input int budget);
        int k = 0;
        while (n_resp < target && k < budget) begin @(negedge sys_clk); k++; end
        #2;
        if (n_resp < target) check("wait_resp", 32'(n_resp), 32'(target));
    endtask

    task automatic wait_idle_drained(input int budget);
        int k = 0;
        while ((busy || m_valid || exp_q.size() != 0) && k < budget) begin
            @(negedge sys_clk); k++;
        end
        #2;
        check("idle_busy", 32'(busy), 0);
        check("drained_q", 32'(exp_q.size()), 0);
    endtask

    task automatic pulse_clr();
        @(negedge sys_clk); clr_err = 1'b1;
        @(negedge sys_clk); clr_err = 1'b0;
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_conv_start"}, 32'(conv_start), 0);
        check({tag, "_ch_sel"},     32'(ch_sel), 0);
        check({tag, "_m_data"},     32'(m_data), 0);
        check({tag, "_m_valid"},    32'(m_valid), 0);
        check({tag, "_busy"},       32'(busy), 0);
        check({tag, "_timeout"},    32'(timeout_err), 0);
        check({tag, "_overflow"},   32'(overflow), 0);
    endtask

    task automatic start_scan(input logic [5:0] m, input int p, input int dly, input int rdy);
        ch_mask = m; period = DIV_W'(p); rsp_delay = dly; ready_mode = rdy;
        exp_ch = first_ch(m); last_start = -1;
        @(negedge sys_clk); enable = 1'b1;
    endtask

    initial begin
        int s0;
        int p0;
        rst_n = 1'b0; enable = 1'b0; period = DIV_W'(100); ch_mask = '0; clr_err = 1'b0;
        step(3);
        check_all_zero("reset");
        @(negedge sys_clk); rst_n = 1'b1;
        step(3);

        // Basic scan over channels 0 and 2 at period 100.
        s0 = n_starts;
        start_scan(6'b000101, 100, 20, 1);
        wait_starts(s0 + 4, 600, "wait_basic");
        enable = 1'b0;
        wait_idle_drained(300);

        // Period below the clamp, random latency and back-pressure.
        s0 = n_starts;
        start_scan(6'b110010, 10, 0, 2);
        wait_starts(s0 + 5, 500, "wait_clamp");
        enable = 1'b0;
        wait_idle_drained(300);

        // Timeout on the first conversion, then the next channel answers.
        s0 = n_starts;
        start_scan(6'b000011, 300, -1, 1);
        wait_starts(s0 + 1, 50, "wait_to_first");
        rsp_delay = 20;
        wait_starts(s0 + 2, 400, "wait_to_second");
        step(30);
        check("timeout_sticky", 32'(timeout_err), 1);
        pulse_clr();
        check("timeout_cleared", 32'(timeout_err), 0);
        check("no_overflow_after_to", 32'(overflow), 0);
        enable = 1'b0;
        wait_idle_drained(300);

        // Overflow with the consumer stalled; single-bit mask keeps ch_sel fixed.
        exp_ovf = 1'b0;
        p0 = n_resp;
        start_scan(6'b001000, 64, 0, 0);
        wait_resp(p0 + 4, 400);
        step(3);
        check("ovf_before_5th", 32'(overflow), 0);
        check("valid_when_full", 32'(m_valid), 1);
        wait_resp(p0 + 5, 200);
        step(3);
        enable = 1'b0;
        check("ovf_model", 32'(exp_ovf), 1);
        check("ovf_on_5th", 32'(overflow), 32'(exp_ovf));
        step(10);
        ready_mode = 1;
        wait_idle_drained(300);
        pulse_clr();
        check("ovf_cleared", 32'(overflow), 0);

        // enable drops mid-conversion: result still stored, no further start.
        s0 = n_starts;
        start_scan(6'b010100, 100, 20, 1);
        wait_starts(s0 + 1, 50, "wait_drop");
        p0 = n_pops;
        step(5);
        enable = 1'b0;
        wait_idle_drained(200);
        check("stored_after_disable", 32'(n_pops), 32'(p0 + 1));
        step(200);
        check("no_restart", 32'(n_starts), 32'(s0 + 1));

        // Reset while in WAIT_DONE with a word held in the FIFO.
        s0 = n_starts;
        start_scan(6'b100110, 100, 20, 0);
        wait_starts(s0 + 1, 50, "wait_rst_first");
        rsp_delay = -1;
        wait_starts(s0 + 2, 200, "wait_rst_second");
        step(10);
        check("valid_before_reset", 32'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        exp_ch = first_ch(ch_mask); last_start = -1; rsp_delay = 20; ready_mode = 1;
        step(3);
        s0 = n_starts;
        rst_n = 1'b1;
        wait_starts(s0 + 2, 300, "wait_restart");
        enable = 1'b0;
        wait_idle_drained(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
